tow_match_scorer: RTL and testbench

Parametrised successor to the tug-of-war point scorer. Tracks rope position over a configurable number of steps per side, applies per-position double-step handicaps on proper pushes, and counts games won per side up to a best-of match result. Sits between the push arbiter (which supplies `winrnd`/`right`/`tie`) and the LED score display and match-status logic.

---
 rtl/tow_match_scorer.sv | 179 +++++++++++++++++
 tb/tb_tow_match_scorer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/tow_match_scorer.sv
// tow_match_scorer: rope position, per-side game wins and best-of match result for tug-of-war.
// Optional feature macro SCORER_DOUBLE_STEP_EN enables per-position double-step handicaps.
module tow_match_scorer #(
  parameter int HALF       = 3,
  parameter int MATCH_WINS = 2,
  parameter int WINW       = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winrnd,
  input  logic              right,
  input  logic              leds_on,
  input  logic              tie,
  input  logic [2*HALF:0]   switches_in,
  output logic [2*HALF+1:0] score,
  output logic [WINW-1:0]   wins_l,
  output logic [WINW-1:0]   wins_r,
  output logic              game_done,
  output logic              match_over,
  output logic              match_winner
);

  localparam int NPOS = 2*HALF + 3;
  localparam int PW   = $clog2(NPOS);

  localparam logic [PW-1:0]   POS_WL     = '0;
  localparam logic [PW-1:0]   POS_N      = PW'(HALF + 1);
  localparam logic [PW-1:0]   POS_WR     = PW'(2*HALF + 2);
  localparam logic [PW:0]     STEP_ONE   = (PW+1)'(1);
  localparam logic [PW:0]     STEP_TWO   = (PW+1)'(2);
  localparam logic [WINW-1:0] WIN_ONE    = WINW'(1);
  localparam logic [WINW-1:0] WIN_TARGET = WINW'(MATCH_WINS);

  typedef enum logic [1:0] {PLAY, GAME_OVER, MATCH_OVER} state_t;

  state_t          state, state_nx;
  logic [PW-1:0]   pos, pos_nx;
  logic [WINW-1:0] wins_l_nx, wins_r_nx;
  logic            game_done_nx, winner_nx;
  logic            push, mr, dbl;
  logic [PW:0]     step, pos_up;

`ifdef SCORER_DOUBLE_STEP_EN
  logic [2*HALF:0] sw_lat, sw_lat_nx;
`else
  logic unused_switches;
  assign unused_switches = ^switches_in;
`endif

  assign push = winrnd & ~tie;
  assign mr   = (right & leds_on) | (~right & ~leds_on);

`ifdef SCORER_DOUBLE_STEP_EN
  // Handicap bit k belongs to rope position k+1; a jumped light is never doubled.
  always_comb begin
    dbl = 1'b0;
    for (int k = 0; k <= 2*HALF; k++) begin
      if (pos == PW'(k + 1)) dbl = leds_on & sw_lat[k];
    end
  end
`else
  assign dbl = 1'b0;
`endif

  assign step   = dbl ? STEP_TWO : STEP_ONE;
  assign pos_up = {1'b0, pos} + step;

  always_comb begin
    state_nx     = state;
    pos_nx       = pos;
    wins_l_nx    = wins_l;
    wins_r_nx    = wins_r;
    game_done_nx = 1'b0;
    winner_nx    = match_winner;
`ifdef SCORER_DOUBLE_STEP_EN
    sw_lat_nx    = sw_lat;
`endif
    case (state)
      PLAY: begin
`ifdef SCORER_DOUBLE_STEP_EN
        if (pos == POS_N) sw_lat_nx = switches_in;
`endif
        if (push) begin
          if (mr) begin
            if (pos_up >= {1'b0, POS_WR}) begin
              pos_nx       = POS_WR;
              wins_r_nx    = wins_r + WIN_ONE;
              game_done_nx = 1'b1;
              if (wins_r_nx == WIN_TARGET) begin
                state_nx  = MATCH_OVER;
                winner_nx = 1'b1;
              end else begin
                state_nx = GAME_OVER;
              end
            end else begin
              pos_nx = pos_up[PW-1:0];
            end
          end else begin
            if ({1'b0, pos} <= step) begin
              pos_nx       = POS_WL;
              wins_l_nx    = wins_l + WIN_ONE;
              game_done_nx = 1'b1;
              if (wins_l_nx == WIN_TARGET) begin
                state_nx  = MATCH_OVER;
                winner_nx = 1'b0;
              end else begin
                state_nx = GAME_OVER;
              end
            end else begin
              pos_nx = pos - step[PW-1:0];
            end
          end
        end
      end
      // The restarting push only recentres the rope; it never moves it.
      GAME_OVER: begin
        if (push) begin
          pos_nx   = POS_N;
          state_nx = PLAY;
`ifdef SCORER_DOUBLE_STEP_EN
          sw_lat_nx = switches_in;
`endif
        end
      end
      MATCH_OVER: begin
        state_nx = MATCH_OVER;
      end
      default: begin
        state_nx = PLAY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= PLAY;
      pos          <= POS_N;
      wins_l       <= '0;
      wins_r       <= '0;
      game_done    <= 1'b0;
      match_winner <= 1'b0;
`ifdef SCORER_DOUBLE_STEP_EN
      sw_lat       <= '0;
`endif
    end else begin
      state        <= state_nx;
      pos          <= pos_nx;
      wins_l       <= wins_l_nx;
      wins_r       <= wins_r_nx;
      game_done    <= game_done_nx;
      match_winner <= winner_nx;
`ifdef SCORER_DOUBLE_STEP_EN
      sw_lat       <= sw_lat_nx;
`endif
    end
  end

  assign match_over = (state == MATCH_OVER);

  // LED word: left positions fill the upper half, right positions the lower half.
  always_comb begin
    score = '0;
    if (pos == POS_WL) begin
      score[2*HALF+1 -: HALF] = '1;
    end else if (pos == POS_WR) begin
      score[HALF-1:0] = '1;
    end else if (pos == POS_N) begin
      score[HALF+1 -: 2] = 2'b11;
    end else begin
      for (int p = 1; p <= HALF; p++) begin
        if (pos == PW'(p)) score[2*HALF+2-p] = 1'b1;
      end
      for (int p = HALF + 2; p <= 2*HALF + 1; p++) begin
        if (pos == PW'(p)) score[2*HALF+1-p] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tow_match_scorer.sv
// Bench for tow_match_scorer: vector table plus hand sequences, checked through an expectation queue.
`timescale 1ns/1ps
module tb_tow_match_scorer;

  localparam int HALF       = 3;
  localparam int MATCH_WINS = 2;
  localparam int WINW       = 2;

  // {winrnd, right, leds_on, tie}
  localparam logic [3:0] IDLE = 4'b0000;
  localparam logic [3:0] PR   = 4'b1110;
  localparam logic [3:0] PL   = 4'b1010;
  localparam logic [3:0] JR   = 4'b1100;
  localparam logic [3:0] JL   = 4'b1000;
  localparam logic [3:0] TIE  = 4'b1111;
  localparam logic [3:0] NOW  = 4'b0110;

  localparam logic [7:0] S_N  = 8'b00011000;
  localparam logic [7:0] S_R1 = 8'b00000100;
  localparam logic [7:0] S_R2 = 8'b00000010;
  localparam logic [7:0] S_R3 = 8'b00000001;
  localparam logic [7:0] S_WR = 8'b00000111;
  localparam logic [7:0] S_L1 = 8'b00100000;
  localparam logic [7:0] S_L2 = 8'b01000000;
  localparam logic [7:0] S_L3 = 8'b10000000;
  localparam logic [7:0] S_WL = 8'b11100000;

  typedef struct packed {
    logic [3:0]        wrlt;
    logic [2*HALF:0]   sw;
    logic [2*HALF+1:0] score;
    logic [WINW-1:0]   wl;
    logic [WINW-1:0]   wr;
    logic [2:0]        flags;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              winrnd, right, leds_on, tie;
  logic [2*HALF:0]   switches_in;
  logic [2*HALF+1:0] score;
  logic [WINW-1:0]   wins_l, wins_r;
  logic              game_done, match_over, match_winner;

  int   compared = 0;
  int   mismatched = 0;
  vec_t sb[$];
  vec_t tbl[$];

  tow_match_scorer #(.HALF(HALF), .MATCH_WINS(MATCH_WINS), .WINW(WINW)) dut (
    .clk          (clk),
    .rst          (rst),
    .winrnd       (winrnd),
    .right        (right),
    .leds_on      (leds_on),
    .tie          (tie),
    .switches_in  (switches_in),
    .score        (score),
    .wins_l       (wins_l),
    .wins_r       (wins_r),
    .game_done    (game_done),
    .match_over   (match_over),
    .match_winner (match_winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [3:0] wrlt, input logic [2*HALF:0] sw,
                              input logic [2*HALF+1:0] sc, input logic [WINW-1:0] wl,
                              input logic [WINW-1:0] wr, input logic [2:0] flags);
    vec_t v;
    v.wrlt  = wrlt;
    v.sw    = sw;
    v.score = sc;
    v.wl    = wl;
    v.wr    = wr;
    v.flags = flags;
    return v;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    vec_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: got no expectation queued, expected one", tag);
    end else begin
      e = sb.pop_front();
      cmp({tag, ".score"},        32'(score),        32'(e.score));
      cmp({tag, ".wins_l"},       32'(wins_l),       32'(e.wl));
      cmp({tag, ".wins_r"},       32'(wins_r),       32'(e.wr));
      cmp({tag, ".game_done"},    32'(game_done),    32'(e.flags[2]));
      cmp({tag, ".match_over"},   32'(match_over),   32'(e.flags[1]));
      cmp({tag, ".match_winner"}, 32'(match_winner), 32'(e.flags[0]));
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    {winrnd, right, leds_on, tie} = v.wrlt;
    switches_in = v.sw;
    sb.push_back(v);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Reset is asserted between edges and must act before the next rising edge.
  task automatic asyncReset(input string tag);
    @(negedge clk);
    {winrnd, right, leds_on, tie} = IDLE;
    switches_in = '0;
    #2 rst = 1'b0;
    #1;
    sb.push_back(mk(IDLE, '0, S_N, 2'd0, 2'd0, 3'b000));
    checkOutput(tag);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic runSeq(input string name);
    for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i], $sformatf("%s%0d", name, i));
    tbl.delete();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b0;
    {winrnd, right, leds_on, tie} = IDLE;
    switches_in = '0;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(mk(IDLE, '0, S_N, 2'd0, 2'd0, 3'b000));
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b1;

    tbl.push_back(mk(IDLE, '0, S_N,  2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PR,   '0, S_R1, 2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PR,   '0, S_R2, 2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PR,   '0, S_R3, 2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PR,   '0, S_WR, 2'd0, 2'd1, 3'b100));
    tbl.push_back(mk(IDLE, '0, S_WR, 2'd0, 2'd1, 3'b000));
    tbl.push_back(mk(TIE,  '0, S_WR, 2'd0, 2'd1, 3'b000));
    tbl.push_back(mk(PL,   '0, S_N,  2'd0, 2'd1, 3'b000));
    tbl.push_back(mk(JR,   '0, S_L1, 2'd0, 2'd1, 3'b000));
    tbl.push_back(mk(TIE,  '0, S_L1, 2'd0, 2'd1, 3'b000));
    tbl.push_back(mk(JL,   '0, S_N,  2'd0, 2'd1, 3'b000));
    tbl.push_back(mk(PL,   '0, S_L1, 2'd0, 2'd1, 3'b000));
    tbl.push_back(mk(PL,   '0, S_L2, 2'd0, 2'd1, 3'b000));
    tbl.push_back(mk(NOW,  '0, S_L2, 2'd0, 2'd1, 3'b000));
    tbl.push_back(mk(PL,   '0, S_L3, 2'd0, 2'd1, 3'b000));
    tbl.push_back(mk(PL,   '0, S_WL, 2'd1, 2'd1, 3'b100));
    tbl.push_back(mk(IDLE, '0, S_WL, 2'd1, 2'd1, 3'b000));
    tbl.push_back(mk(PR,   '0, S_N,  2'd1, 2'd1, 3'b000));
    tbl.push_back(mk(PR,   '0, S_R1, 2'd1, 2'd1, 3'b000));
    tbl.push_back(mk(PR,   '0, S_R2, 2'd1, 2'd1, 3'b000));
    tbl.push_back(mk(PR,   '0, S_R3, 2'd1, 2'd1, 3'b000));
    tbl.push_back(mk(PR,   '0, S_WR, 2'd1, 2'd2, 3'b111));
    tbl.push_back(mk(IDLE, '0, S_WR, 2'd1, 2'd2, 3'b011));
    tbl.push_back(mk(PL,   '0, S_WR, 2'd1, 2'd2, 3'b011));
    tbl.push_back(mk(PR,   '0, S_WR, 2'd1, 2'd2, 3'b011));
    runSeq("main");
    asyncReset("rst_in_match_over");

    tbl.push_back(mk(PL, '0, S_L1, 2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PL, '0, S_L2, 2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PL, '0, S_L3, 2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PL, '0, S_WL, 2'd1, 2'd0, 3'b100));
    tbl.push_back(mk(PR, '0, S_N,  2'd1, 2'd0, 3'b000));
    tbl.push_back(mk(PL, '0, S_L1, 2'd1, 2'd0, 3'b000));
    tbl.push_back(mk(PL, '0, S_L2, 2'd1, 2'd0, 3'b000));
    runSeq("to_l2_");
    asyncReset("rst_at_l2");

`ifdef SCORER_DOUBLE_STEP_EN
    tbl.push_back(mk(IDLE, 7'b0001000, S_N,  2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PR,   7'b0001000, S_R2, 2'd0, 2'd0, 3'b000));
    runSeq("dbl_proper");
    asyncReset("rst_dbl1");

    tbl.push_back(mk(IDLE, 7'b0001000, S_N,  2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(JR,   7'b0001000, S_L1, 2'd0, 2'd0, 3'b000));
    runSeq("dbl_jump");
    asyncReset("rst_dbl2");

    tbl.push_back(mk(IDLE, 7'b1000000, S_N,  2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PR,   7'b1000000, S_R1, 2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PR,   7'b0000000, S_R2, 2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PR,   7'b0000000, S_R3, 2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PR,   7'b0000000, S_WR, 2'd0, 2'd1, 3'b100));
    runSeq("dbl_sat");
`else
    tbl.push_back(mk(IDLE, 7'b1111111, S_N,  2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PR,   7'b1111111, S_R1, 2'd0, 2'd0, 3'b000));
    tbl.push_back(mk(PR,   7'b1111111, S_R2, 2'd0, 2'd0, 3'b000));
    runSeq("single_step");
`endif

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL leftover: got %0d queued expectations, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
